bias_weight: RTL and testbench

Parameter store and learning-update block for one fully connected layer of the on-chip training network, between a previous layer of NP neurons and a current layer of NC neurons. It holds NC biases and NP×NC weights. It serves them to the forward datapath (bias + weight bundle) and to the backward datapath (transposed weights). In training mode it applies one SGD step per sample from the captured previous-layer state and current-layer delta.

---
 rtl/bias_weight.sv | 184 ++++++++++++++++++
 tb/tb_bias_weight.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_weight.sv
// Bias/weight store and SGD update for one fully connected layer (NP inputs, NC outputs).
// Define BIASWEIGHT_SAT_EN to saturate parameter updates; otherwise they wrap modulo 2^WV.
module bias_weight #(
  parameter int    NP    = 3,
  parameter int    NC    = 2,
  parameter int    WV    = 8,
  parameter string BURST = "yes"
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iMode,
  input  logic [WV-1:0]            iLR,
  input  logic                     iValid_AS_State1,
  output logic                     oReady_AS_State1,
  input  logic [NP*WV-1:0]         iData_AS_State1,
  input  logic                     iValid_AS_Delta1,
  output logic                     oReady_AS_Delta1,
  input  logic [NC*WV-1:0]         iData_AS_Delta1,
  output logic                     oValid_BM_WeightBias,
  input  logic                     iReady_BM_WeightBias,
  output logic [NC*NP*WV+NC*WV-1:0] oData_BM_WeightBias,
  output logic                     oValid_BM_Weight,
  input  logic                     iReady_BM_Weight,
  output logic [NP*NC*WV-1:0]      oData_BM_Weight,
  output logic [1:0]               oDbgState
);

  localparam bit BURST_EN = (BURST == "yes");
  // Full-precision width of delta*state*lr (two signed WV values times an unsigned WV value).
  localparam int PW = 3 * WV + 1;

  typedef enum logic [1:0] {
    S_FWD        = 2'd0,
    S_WAIT_DELTA = 2'd1,
    S_BWD        = 2'd2,
    S_UPDATE     = 2'd3
  } state_e;

  state_e                state_q;
  logic                  wb_sent_q;
  logic [NP*WV-1:0]      r_state_q;
  logic [NC*WV-1:0]      r_delta_q;
  logic [NC*WV-1:0]      r_bias_q;
  logic [NP*NC*WV-1:0]   r_weight_q;
  logic [NC*WV-1:0]      r_bias_d;
  logic [NP*NC*WV-1:0]   r_weight_d;

  logic st_hs;
  logic dl_hs;
  logic w_hs;
  logic wb_hs;

  function automatic logic signed [PW-1:0] sext(input logic [WV-1:0] v);
    return {{(PW-WV){v[WV-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] zext(input logic [WV-1:0] v);
    return {{(PW-WV){1'b0}}, v};
  endfunction

  function automatic logic signed [PW-1:0] weight_grad(input logic [WV-1:0] d,
                                                       input logic [WV-1:0] s,
                                                       input logic [WV-1:0] lr);
    logic signed [PW-1:0] prod;
    prod = sext(d) * sext(s) * zext(lr);
    return prod >>> (3 * WV / 2);
  endfunction

  function automatic logic signed [PW-1:0] bias_grad(input logic [WV-1:0] d,
                                                     input logic [WV-1:0] lr);
    logic signed [PW-1:0] prod;
    prod = sext(d) * zext(lr);
    return prod >>> WV;
  endfunction

  function automatic logic [WV-1:0] sub_fit(input logic [WV-1:0]        a,
                                            input logic signed [PW-1:0] g);
    logic signed [PW:0] diff;
    diff = {{(PW+1-WV){a[WV-1]}}, a} - {g[PW-1], g};
`ifdef BIASWEIGHT_SAT_EN
    begin
      logic signed [PW:0] lim_hi;
      logic signed [PW:0] lim_lo;
      lim_hi         = '0;
      lim_hi[WV-2:0] = '1;
      lim_lo         = '1;
      lim_lo[WV-2:0] = '0;
      if (diff > lim_hi) return lim_hi[WV-1:0];
      if (diff < lim_lo) return lim_lo[WV-1:0];
    end
`endif
    return diff[WV-1:0];
  endfunction

  // valid/ready: a transfer happens on the rising edge where both are high; our valid and
  // ready outputs are decoded from registered state and iMode only, never from the peer's signal.
  assign oReady_AS_State1     = (state_q == S_FWD) && iMode;
  assign oReady_AS_Delta1     = (state_q == S_WAIT_DELTA) && iMode;
  assign oValid_BM_Weight     = (state_q == S_BWD) && iMode;
  assign oValid_BM_WeightBias = (state_q != S_UPDATE) && (BURST_EN || !wb_sent_q);
  assign oDbgState            = state_q;

  assign st_hs = oReady_AS_State1 && iValid_AS_State1;
  assign dl_hs = oReady_AS_Delta1 && iValid_AS_Delta1;
  assign w_hs  = oValid_BM_Weight && iReady_BM_Weight;
  assign wb_hs = oValid_BM_WeightBias && iReady_BM_WeightBias;

  assign oData_BM_Weight = r_weight_q;

  // Forward bundle groups weights by output neuron j so each column is contiguous.
  always_comb begin
    oData_BM_WeightBias = '0;
    for (int j = 0; j < NC; j++) begin
      oData_BM_WeightBias[j*WV +: WV] = r_bias_q[j*WV +: WV];
      for (int i = 0; i < NP; i++) begin
        oData_BM_WeightBias[NC*WV + j*NP*WV + i*WV +: WV] = r_weight_q[i*NC*WV + j*WV +: WV];
      end
    end
  end

  always_comb begin
    r_bias_d   = r_bias_q;
    r_weight_d = r_weight_q;
    for (int j = 0; j < NC; j++) begin
      r_bias_d[j*WV +: WV] = sub_fit(r_bias_q[j*WV +: WV],
                                     bias_grad(r_delta_q[j*WV +: WV], iLR));
      for (int i = 0; i < NP; i++) begin
        r_weight_d[i*NC*WV + j*WV +: WV] =
          sub_fit(r_weight_q[i*NC*WV + j*WV +: WV],
                  weight_grad(r_delta_q[j*WV +: WV], r_state_q[i*WV +: WV], iLR));
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_FWD;
      wb_sent_q  <= 1'b0;
      r_state_q  <= '0;
      r_delta_q  <= '0;
      r_bias_q   <= '0;
      r_weight_q <= '0;
    end else begin
      // wb_sent only gates valid in single-transfer mode; inference idles re-arm it.
      if (wb_hs) begin
        wb_sent_q <= 1'b1;
      end else if ((state_q == S_UPDATE) ||
                   (!BURST_EN && !iMode && !iReady_BM_WeightBias)) begin
        wb_sent_q <= 1'b0;
      end

      case (state_q)
        S_FWD: begin
          if (st_hs) begin
            r_state_q <= iData_AS_State1;
            state_q   <= S_WAIT_DELTA;
          end
        end
        S_WAIT_DELTA: begin
          if (!iMode) begin
            state_q <= S_FWD;
          end else if (dl_hs) begin
            r_delta_q <= iData_AS_Delta1;
            state_q   <= S_BWD;
          end
        end
        S_BWD: begin
          if (!iMode) begin
            state_q <= S_FWD;
          end else if (w_hs) begin
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_bias_q   <= r_bias_d;
          r_weight_q <= r_weight_d;
          state_q    <= S_FWD;
        end
        default: state_q <= S_FWD;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_weight.sv
// Bench for bias_weight: directed steps plus random SGD samples against an arithmetic model.
module tb_bias_weight;

  localparam int NP  = 3;
  localparam int NC  = 2;
  localparam int WV  = 8;
  localparam int WBW = NC*NP*WV + NC*WV;
  localparam int WW  = NP*NC*WV;

  logic             clk;
  logic             rst;
  logic             mode;
  logic [WV-1:0]    lr;
  logic             st_v;
  logic [NP*WV-1:0] st_d;
  logic             dl_v;
  logic [NC*WV-1:0] dl_d;
  logic             wb_rdy;
  logic             w_rdy;
  logic             wb_rdy_nb;

  logic             st_rdy, dl_rdy, wb_v, w_v;
  logic [WBW-1:0]   wb_d;
  logic [WW-1:0]    w_d;
  logic [1:0]       dbg;
  logic             nb_st_rdy, nb_dl_rdy, nb_wb_v, nb_w_v;
  logic [WBW-1:0]   nb_wb_d;
  logic [WW-1:0]    nb_w_d;
  logic [1:0]       nb_dbg;

  int total;
  int bad;
  int nb_hs;

  // reference model
  int m_w[NP][NC];
  int m_b[NC];
  int cur_s[NP];
  int cur_d[NC];
  int cur_lr;

  bias_weight #(.NP(NP), .NC(NC), .WV(WV), .BURST("yes")) dut (
    .iCLK(clk), .iRST(rst), .iMode(mode), .iLR(lr),
    .iValid_AS_State1(st_v), .oReady_AS_State1(st_rdy), .iData_AS_State1(st_d),
    .iValid_AS_Delta1(dl_v), .oReady_AS_Delta1(dl_rdy), .iData_AS_Delta1(dl_d),
    .oValid_BM_WeightBias(wb_v), .iReady_BM_WeightBias(wb_rdy), .oData_BM_WeightBias(wb_d),
    .oValid_BM_Weight(w_v), .iReady_BM_Weight(w_rdy), .oData_BM_Weight(w_d),
    .oDbgState(dbg)
  );

  bias_weight #(.NP(NP), .NC(NC), .WV(WV), .BURST("no")) dut_nb (
    .iCLK(clk), .iRST(rst), .iMode(mode), .iLR(lr),
    .iValid_AS_State1(st_v), .oReady_AS_State1(nb_st_rdy), .iData_AS_State1(st_d),
    .iValid_AS_Delta1(dl_v), .oReady_AS_Delta1(nb_dl_rdy), .iData_AS_Delta1(dl_d),
    .oValid_BM_WeightBias(nb_wb_v), .iReady_BM_WeightBias(wb_rdy_nb), .oData_BM_WeightBias(nb_wb_d),
    .oValid_BM_Weight(nb_w_v), .iReady_BM_Weight(w_rdy), .oData_BM_Weight(nb_w_d),
    .oDbgState(nb_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int fit(input longint x);
    longint hi;
    longint lo;
    longint m;
    hi = (longint'(1) << (WV-1)) - 1;
    lo = -(longint'(1) << (WV-1));
`ifdef BIASWEIGHT_SAT_EN
    if (x > hi) return int'(hi);
    if (x < lo) return int'(lo);
    return int'(x);
`else
    m = x % (longint'(1) << WV);
    if (m < 0) m = m + (longint'(1) << WV);
    if (m > hi) m = m - (longint'(1) << WV);
    return int'(m);
`endif
  endfunction

  function automatic void model_update();
    longint p;
    for (int i = 0; i < NP; i++) begin
      for (int j = 0; j < NC; j++) begin
        p = longint'(cur_d[j]) * cur_s[i] * cur_lr;
        m_w[i][j] = fit(m_w[i][j] - fdiv(p, longint'(1) << (3*WV/2)));
      end
    end
    for (int j = 0; j < NC; j++) begin
      p = longint'(cur_d[j]) * cur_lr;
      m_b[j] = fit(m_b[j] - fdiv(p, longint'(1) << WV));
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < NC; j++) m_w[i][j] = 0;
    for (int j = 0; j < NC; j++) m_b[j] = 0;
  endfunction

  function automatic logic [WBW-1:0] exp_wb();
    logic [WBW-1:0] v;
    v = '0;
    for (int j = 0; j < NC; j++) begin
      v[j*WV +: WV] = WV'(m_b[j]);
      for (int i = 0; i < NP; i++) v[NC*WV + j*NP*WV + i*WV +: WV] = WV'(m_w[i][j]);
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] exp_w();
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < NC; j++) v[i*NC*WV + j*WV +: WV] = WV'(m_w[i][j]);
    return v;
  endfunction

  function automatic logic [NC*WV-1:0] exp_b();
    logic [NC*WV-1:0] v;
    for (int j = 0; j < NC; j++) v[j*WV +: WV] = WV'(m_b[j]);
    return v;
  endfunction

  // driver tasks
  task automatic step();
    #2;
    if (nb_wb_v && wb_rdy_nb) nb_hs++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload_default();
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < NC; j++) m_w[i][j] = i*NC + j;
    for (int j = 0; j < NC; j++) m_b[j] = j;
    dut.r_weight_q = exp_w();
    dut.r_bias_q   = exp_b();
  endtask

  task automatic drive_data();
    for (int i = 0; i < NP; i++) st_d[i*WV +: WV] = WV'(cur_s[i]);
    for (int j = 0; j < NC; j++) dl_d[j*WV +: WV] = WV'(cur_d[j]);
    lr = WV'(cur_lr);
  endtask

  task automatic run_sample(input string tag);
    int nb_start;
    drive_data();
    mode      = 1'b1;
    wb_rdy    = 1'b1;
    wb_rdy_nb = 1'b1;
    nb_start  = nb_hs;
    repeat ($urandom_range(0, 2)) step();
    st_v = 1'b1;
    #1 chk({tag, "_st_ready"}, st_rdy, 1'b1);
    step();
    st_v = 1'b0;
    #1 chk({tag, "_dl_ready"}, dl_rdy, 1'b1);
    repeat ($urandom_range(0, 2)) step();
    dl_v = 1'b1;
    step();
    dl_v = 1'b0;
    #1 chk({tag, "_bwd_valid"}, w_v, 1'b1);
    chk({tag, "_bwd_old_w"}, w_d, exp_w());
    chk({tag, "_nb_wb_held"}, nb_wb_v, 1'b0);
    repeat ($urandom_range(0, 2)) step();
    w_rdy = 1'b1;
    step();
    w_rdy = 1'b0;
    #1 chk({tag, "_upd_wb_valid"}, wb_v, 1'b0);
    chk({tag, "_upd_w_valid"}, w_v, 1'b0);
    model_update();
    step();
    #1 chk({tag, "_bundle"}, wb_d, exp_wb());
    chk({tag, "_weights"}, w_d, exp_w());
    chk({tag, "_nb_one_xfer"}, nb_hs - nb_start, 1);
    chk({tag, "_nb_revalid"}, nb_wb_v, 1'b1);
  endtask

  initial begin
    logic [WBW-1:0] inf_bundle;
    logic [2:0]     rdy_pat;
    total = 0; bad = 0; nb_hs = 0;
    rst = 1'b1; mode = 1'b0; lr = '0;
    st_v = 1'b0; st_d = '0; dl_v = 1'b0; dl_d = '0;
    wb_rdy = 1'b0; w_rdy = 1'b0; wb_rdy_nb = 1'b0;
    model_clear();
    @(negedge clk);
    repeat (2) step();
    rst = 1'b0;

    // reset state
    #1 chk("rst_wb_valid", wb_v, 1'b1);
    chk("rst_st_ready", st_rdy, 1'b0);
    chk("rst_dl_ready", dl_rdy, 1'b0);
    chk("rst_w_valid", w_v, 1'b0);
    chk("rst_wb_data", wb_d, '0);
    chk("rst_w_data", w_d, '0);
    chk("rst_nb_wb_valid", nb_wb_v, 1'b1);
    mode = 1'b1;
    #1 chk("rst_st_ready_mode1", st_rdy, 1'b1);
    mode = 1'b0;

    // inference: ready toggled, nothing accepted, bundle unchanged
    preload_default();
    inf_bundle = 64'h0503010402000100;
    st_v = 1'b1;
    dl_v = 1'b1;
    rdy_pat = 3'b101;
    for (int k = 0; k < 3; k++) begin
      wb_rdy    = rdy_pat[k];
      wb_rdy_nb = rdy_pat[k];
      #1 chk("inf_wb_valid", wb_v, 1'b1);
      chk("inf_st_ready", st_rdy, 1'b0);
      chk("inf_dl_ready", dl_rdy, 1'b0);
      chk("inf_bundle", wb_d, inf_bundle);
      step();
    end
    st_v = 1'b0;
    dl_v = 1'b0;
    chk("inf_bundle_after", wb_d, inf_bundle);
    chk("inf_w_valid", w_v, 1'b0);
    chk("inf_nb_sent", nb_wb_v, 1'b0);
    wb_rdy_nb = 1'b0;
    step();
    chk("inf_nb_rearm", nb_wb_v, 1'b1);

    // directed training sample
    chk("pre_weights", w_d, 48'h050403020100);
    cur_s  = '{10, 20, 30};
    cur_d  = '{10, 20};
    cur_lr = 15;
    run_sample("dir");
    chk("dir_w_literal", w_d, 48'h030302020100);
    chk("dir_b_literal", wb_d[NC*WV-1:0], 16'h0000);

    // iMode dropped in WAIT_DELTA
    mode = 1'b1;
    st_v = 1'b1;
    step();
    st_v = 1'b0;
    mode = 1'b0;
    dl_v = 1'b1;
    #1 chk("drop_dl_ready", dl_rdy, 1'b0);
    step();
    step();
    dl_v = 1'b0;
    mode = 1'b1;
    #1 chk("drop_back_fwd", st_rdy, 1'b1);
    chk("drop_no_delta", dl_rdy, 1'b0);
    chk("drop_weights", w_d, exp_w());
    chk("drop_bundle", wb_d, exp_wb());
    mode = 1'b0;
    wb_rdy_nb = 1'b0;
    step();

    // extreme operands: saturate or wrap
    preload_default();
    m_w[0][0] = 127;
    dut.r_weight_q = exp_w();
    cur_s  = '{127, 0, 0};
    cur_d  = '{-128, 0};
    cur_lr = 255;
    run_sample("ext");
`ifdef BIASWEIGHT_SAT_EN
    chk("ext_w00_literal", w_d[WV-1:0], 8'd127);
`else
    chk("ext_w00_literal", w_d[WV-1:0], 8'd116);
`endif

    // reset in the middle of a sample
    mode = 1'b1;
    st_v = 1'b1;
    step();
    st_v = 1'b0;
    dl_v = 1'b1;
    step();
    dl_v = 1'b0;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    model_clear();
    #1 chk("mrst_w_valid", w_v, 1'b0);
    chk("mrst_wb_valid", wb_v, 1'b1);
    chk("mrst_wb_data", wb_d, '0);
    chk("mrst_w_data", w_d, '0);

    // random samples
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NP; i++) cur_s[i] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < NC; j++) cur_d[j] = int'($urandom_range(0, 255)) - 128;
      cur_lr = int'($urandom_range(0, 255));
      run_sample("rnd");
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
